// File: rtl/imem_port_arbiter_if.sv
// Bundle between the imem arbiter, its two requesters (IF fetch, loader/debug) and the imem macro.
// slave: the arbiter's view. master: the requester/memory side's view.
interface imem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              ld_req;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_last;
    logic              ld_gnt;
    logic              ld_rvalid;
    logic [DATA_W-1:0] ld_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  ld_req, ld_we, ld_addr, ld_wdata, ld_last,
        output ld_gnt, ld_rvalid, ld_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output ld_req, ld_we, ld_addr, ld_wdata, ld_last,
        input  ld_gnt, ld_rvalid, ld_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy
    );
endinterface

// File: rtl/imem_port_arbiter.sv
// Single-port imem arbiter: fetch has priority, starvation counter forces loader slots.
// Define IMEM_LD_LOCK_EN to lock the memory to the loader for the length of a burst.
//
// state   | meaning
// ST_ARB  | per-cycle arbitration, fetch first unless the loader is starved
// ST_LOCK | loader burst in progress, only ld_req is granted (IMEM_LD_LOCK_EN only)
module imem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 8
) (
    input logic                clk,
    input logic                rst_n,
    imem_port_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    typedef enum logic {ST_ARB, ST_LOCK} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_owner_q, rsp_owner_d;   // 1 = loader owns the response
    logic [DATA_W-1:0] if_hold_q, if_hold_d;
    logic [DATA_W-1:0] ld_hold_q, ld_hold_d;

    logic gnt_if, gnt_ld, starved, lock_active;
    logic unused_bits;

    assign unused_bits = ^{bus.if_addr[1:0], bus.ld_addr[1:0], bus.ld_last};

    assign lock_active = (state_q == ST_LOCK);
    assign starved     = bus.ld_req && (starve_cnt_q == CNT_MAX);

    // Grants are gated by rst_n so every output reads 0 while reset is asserted.
    always_comb begin
        gnt_if = 1'b0;
        gnt_ld = 1'b0;
        if (rst_n) begin
            if (lock_active)
                gnt_ld = bus.ld_req;
            else if (bus.if_req && !starved)
                gnt_if = 1'b1;
            else
                gnt_ld = bus.ld_req;
        end
    end

    assign bus.if_gnt    = gnt_if;
    assign bus.ld_gnt    = gnt_ld;
    assign bus.mem_en    = gnt_if | gnt_ld;
    assign bus.mem_we    = gnt_ld & bus.ld_we;
    assign bus.mem_addr  = gnt_ld ? bus.ld_addr[ADDR_W-1:2] :
                           gnt_if ? bus.if_addr[ADDR_W-1:2] : '0;
    assign bus.mem_wdata = (gnt_ld && bus.ld_we) ? bus.ld_wdata : '0;

    assign bus.if_rvalid = rsp_valid_q & ~rsp_owner_q;
    assign bus.ld_rvalid = rsp_valid_q &  rsp_owner_q;
    assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : if_hold_q;
    assign bus.ld_rdata  = bus.ld_rvalid ? bus.mem_rdata : ld_hold_q;
    assign bus.busy      = lock_active | rsp_valid_q;

    always_comb begin
        rsp_valid_d = gnt_if | (gnt_ld & ~bus.ld_we);
        rsp_owner_d = gnt_ld;

        if_hold_d = if_hold_q;
        ld_hold_d = ld_hold_q;
        if (bus.if_rvalid) if_hold_d = bus.mem_rdata;
        if (bus.ld_rvalid) ld_hold_d = bus.mem_rdata;

        starve_cnt_d = starve_cnt_q;
        if (!lock_active) begin
            if (!bus.ld_req || gnt_ld)
                starve_cnt_d = '0;
            else if (gnt_if && starve_cnt_q != CNT_MAX)
                starve_cnt_d = starve_cnt_q + 1'b1;
        end

        state_d = state_q;
`ifdef IMEM_LD_LOCK_EN
        if (gnt_ld)
            state_d = bus.ld_last ? ST_ARB : ST_LOCK;
`else
        state_d = ST_ARB;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_ARB;
            starve_cnt_q <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_owner_q  <= 1'b0;
            if_hold_q    <= '0;
            ld_hold_q    <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_owner_q  <= rsp_owner_d;
            if_hold_q    <= if_hold_d;
            ld_hold_q    <= ld_hold_d;
        end
    end
endmodule
